regfile_decode_stage: RTL and testbench



---
 rtl/regfile_decode_stage.sv | 117 +++++++++++
 tb/tb_regfile_decode_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_decode_stage.sv
// Decode stage: architectural register file with icode-driven source selection,
// combinational read ports and two clocked write-back ports (E, M) with optional bypass.
module regfile_decode_stage #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned NUM_REGS = 15,
    parameter int unsigned RSP_IDX  = 4,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [3:0]        icode_i,
    input  logic [ADDR_W-1:0] rA_i,
    input  logic [ADDR_W-1:0] rB_i,
    input  logic [ADDR_W-1:0] dstE_i,
    input  logic [DATA_W-1:0] valE_i,
    input  logic [ADDR_W-1:0] dstM_i,
    input  logic [DATA_W-1:0] valM_i,
    output logic [ADDR_W-1:0] srcA_o,
    output logic [ADDR_W-1:0] srcB_o,
    output logic [DATA_W-1:0] valA_o,
    output logic [DATA_W-1:0] valB_o
);

    localparam logic [ADDR_W-1:0] RNONE = '1;
    localparam logic [ADDR_W-1:0] RSP   = ADDR_W'(RSP_IDX);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    logic [ADDR_W-1:0] srcA, srcB;
    logic [DATA_W-1:0] storedA, storedB;
    logic              we_e, we_m;

    function automatic logic idx_ok(input logic [ADDR_W-1:0] idx);
        return (idx != RNONE) && (32'(idx) < NUM_REGS);
    endfunction

    // M has priority over E for forwarding, matching the write ordering below.
    function automatic logic [DATA_W-1:0] bypass_sel(
        input logic [ADDR_W-1:0] src,
        input logic [DATA_W-1:0] stored,
        input logic              m_ok,
        input logic [ADDR_W-1:0] dst_m,
        input logic [DATA_W-1:0] val_m,
        input logic              e_ok,
        input logic [ADDR_W-1:0] dst_e,
        input logic [DATA_W-1:0] val_e
    );
        logic [DATA_W-1:0] res;
        res = stored;
        if (BYPASS != 0) begin
            if (m_ok && src == dst_m)
                res = val_m;
            else if (e_ok && src == dst_e)
                res = val_e;
        end
        return res;
    endfunction

    assign we_e = idx_ok(dstE_i);
    assign we_m = idx_ok(dstM_i);

    always_comb begin
        unique case (icode_i)
            4'h2, 4'h4, 4'h6, 4'hA: srcA = rA_i;
            4'h9, 4'hB:             srcA = RSP;
            default:                srcA = RNONE;
        endcase
    end

    always_comb begin
        unique case (icode_i)
            4'h4, 4'h5, 4'h6:       srcB = rB_i;
            4'h8, 4'h9, 4'hA, 4'hB: srcB = RSP;
            default:                srcB = RNONE;
        endcase
    end

    // RNONE and out-of-range indices never match a slot, so they read zero.
    always_comb begin
        storedA = '0;
        storedB = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (srcA == ADDR_W'(i)) storedA = regs_q[i];
            if (srcB == ADDR_W'(i)) storedB = regs_q[i];
        end
    end

    assign srcA_o = srcA;
    assign srcB_o = srcB;
    assign valA_o = idx_ok(srcA)
                  ? bypass_sel(srcA, storedA, we_m, dstM_i, valM_i, we_e, dstE_i, valE_i)
                  : '0;
    assign valB_o = idx_ok(srcB)
                  ? bypass_sel(srcB, storedB, we_m, dstM_i, valM_i, we_e, dstE_i, valE_i)
                  : '0;

    // M is applied after E so a same-index collision keeps valM (popq %rsp).
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (we_e && dstE_i == ADDR_W'(i)) regs_d[i] = valE_i;
            if (we_m && dstM_i == ADDR_W'(i)) regs_d[i] = valM_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < int'(NUM_REGS); i++)
                regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: tb/tb_regfile_decode_stage.sv
// Directed bench for regfile_decode_stage: one bypassing and one non-bypassing instance
// share the same stimulus; expected values are hand-computed constants.
module tb_regfile_decode_stage;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [3:0]  icode_i;
    logic [3:0]  rA_i, rB_i, dstE_i, dstM_i;
    logic [63:0] valE_i, valM_i;
    logic [3:0]  srcA_o, srcB_o, srcA0_o, srcB0_o;
    logic [63:0] valA_o, valB_o, valA0_o, valB0_o;

    int nvec = 0;
    int nmis = 0;

    always #5 clk_i = ~clk_i;

    regfile_decode_stage #(.BYPASS(1)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .icode_i(icode_i), .rA_i(rA_i), .rB_i(rB_i),
        .dstE_i(dstE_i), .valE_i(valE_i), .dstM_i(dstM_i), .valM_i(valM_i),
        .srcA_o(srcA_o), .srcB_o(srcB_o), .valA_o(valA_o), .valB_o(valB_o)
    );

    regfile_decode_stage #(.BYPASS(0)) dut_nb (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .icode_i(icode_i), .rA_i(rA_i), .rB_i(rB_i),
        .dstE_i(dstE_i), .valE_i(valE_i), .dstM_i(dstM_i), .valM_i(valM_i),
        .srcA_o(srcA0_o), .srcB_o(srcB0_o), .valA_o(valA0_o), .valB_o(valB0_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_wb();
        dstE_i = 4'hF; valE_i = '0;
        dstM_i = 4'hF; valM_i = '0;
    endtask

    task automatic edge_step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_n_i = 1'b0;
        icode_i = 4'h0; rA_i = 4'h0; rB_i = 4'h0;
        idle_wb();
        #12 rst_n_i = 1'b1;
        @(negedge clk_i);

        // reset state and rrmovq-style decode
        icode_i = 4'h6; rA_i = 4'h1; rB_i = 4'h2;
        #1;
        chk("rst_srcA", 64'(srcA_o), 64'h1);
        chk("rst_srcB", 64'(srcB_o), 64'h2);
        chk("rst_valA", valA_o, 64'h0);
        chk("rst_valB", valB_o, 64'h0);

        // E then M write-back on consecutive edges
        dstE_i = 4'h1; valE_i = 64'h1111;
        edge_step();
        idle_wb();
        dstM_i = 4'h2; valM_i = 64'h2222;
        edge_step();
        idle_wb();
        #1;
        chk("wb_valA", valA_o, 64'h1111);
        chk("wb_valB", valB_o, 64'h2222);
        chk("wb_valA_nb", valA0_o, 64'h1111);
        chk("wb_valB_nb", valB0_o, 64'h2222);

        // same-cycle forwarding vs stored-only read
        icode_i = 4'h2; rA_i = 4'h3;
        dstE_i = 4'h3; valE_i = 64'hAA;
        #1;
        chk("byp_srcB", 64'(srcB_o), 64'hF);
        chk("byp_valA_pre", valA_o, 64'hAA);
        chk("nb_valA_pre", valA0_o, 64'h0);
        chk("byp_valB_rnone", valB_o, 64'h0);
        edge_step();
        idle_wb();
        #1;
        chk("nb_valA_post", valA0_o, 64'hAA);
        chk("byp_valA_post", valA_o, 64'hAA);

        // E and M to the same register: M wins, both for bypass and storage
        icode_i = 4'hB;
        dstE_i = 4'h4; valE_i = 64'h10;
        dstM_i = 4'h4; valM_i = 64'h20;
        #1;
        chk("pop_srcA", 64'(srcA_o), 64'h4);
        chk("pop_srcB", 64'(srcB_o), 64'h4);
        chk("pop_byp_valA", valA_o, 64'h20);
        chk("pop_nb_valA_pre", valA0_o, 64'h0);
        edge_step();
        idle_wb();
        #1;
        chk("pop_valA", valA_o, 64'h20);
        chk("pop_valB", valB_o, 64'h20);
        chk("pop_nb_valB", valB0_o, 64'h20);

        // E-only bypass where M targets elsewhere
        icode_i = 4'h6; rA_i = 4'h5; rB_i = 4'h6;
        dstE_i = 4'h5; valE_i = 64'h55; dstM_i = 4'h6; valM_i = 64'h66;
        #1;
        chk("dual_byp_valA", valA_o, 64'h55);
        chk("dual_byp_valB", valB_o, 64'h66);
        edge_step();
        idle_wb();

        // top implemented index and register 0
        dstE_i = 4'hE; valE_i = 64'hEEEE_0000_0000_EEEE;
        dstM_i = 4'h0; valM_i = 64'hFFFF_FFFF_FFFF_FFFF;
        edge_step();
        idle_wb();
        icode_i = 4'h6; rA_i = 4'hE; rB_i = 4'h0;
        #1;
        chk("r14_valA", valA_o, 64'hEEEE_0000_0000_EEEE);
        chk("r0_valB", valB_o, 64'hFFFF_FFFF_FFFF_FFFF);

        // halt decodes no sources; write to RNONE is dropped
        icode_i = 4'h0; rA_i = 4'h1; rB_i = 4'h2;
        dstE_i = 4'hF; valE_i = 64'hDEAD;
        dstM_i = 4'hF; valM_i = 64'hBEEF;
        #1;
        chk("halt_srcA", 64'(srcA_o), 64'hF);
        chk("halt_srcB", 64'(srcB_o), 64'hF);
        chk("halt_valA", valA_o, 64'h0);
        chk("halt_valB", valB_o, 64'h0);
        edge_step();
        idle_wb();
        icode_i = 4'h6;
        for (int r = 0; r < 15; r++) begin
            logic [63:0] exp_v;
            case (r)
                0:  exp_v = 64'hFFFF_FFFF_FFFF_FFFF;
                1:  exp_v = 64'h1111;
                2:  exp_v = 64'h2222;
                3:  exp_v = 64'hAA;
                4:  exp_v = 64'h20;
                5:  exp_v = 64'h55;
                6:  exp_v = 64'h66;
                14: exp_v = 64'hEEEE_0000_0000_EEEE;
                default: exp_v = 64'h0;
            endcase
            rA_i = 4'(r);
            #1;
            chk($sformatf("scan_r%0d", r), valA0_o, exp_v);
        end

        // asynchronous reset between edges, and a write presented during reset
        rA_i = 4'h1; rB_i = 4'h2;
        @(negedge clk_i);
        #1;
        chk("pre_rst_valA", valA_o, 64'h1111);
        rst_n_i = 1'b0;
        #1;
        chk("arst_valA", valA_o, 64'h0);
        chk("arst_valB", valB_o, 64'h0);
        chk("arst_valB_nb", valB0_o, 64'h0);
        dstE_i = 4'h1; valE_i = 64'h5555;
        #1;
        chk("arst_byp_valA", valA_o, 64'h5555);
        chk("arst_nb_valA", valA0_o, 64'h0);
        edge_step();
        idle_wb();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        #1;
        chk("post_rst_valA", valA_o, 64'h0);
        chk("post_rst_valA_nb", valA0_o, 64'h0);

        // RET: srcA and srcB both RSP
        icode_i = 4'h9;
        dstM_i = 4'h4; valM_i = 64'h4000;
        edge_step();
        idle_wb();
        #1;
        chk("ret_srcA", 64'(srcA_o), 64'h4);
        chk("ret_valB", valB0_o, 64'h4000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
